// File: rtl/br32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br32_pkg
// Description : Shared constants and types for the br32 writeback stage:
//               system register indices, trap cause codes, WB state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package br32_pkg;

    // System register indices (3-bit map, 6 and 7 are unimplemented)
    localparam logic [2:0] SR_EPC     = 3'd0;
    localparam logic [2:0] SR_ECAUSE  = 3'd1;
    localparam logic [2:0] SR_EVEC    = 3'd2;
    localparam logic [2:0] SR_ESTAT   = 3'd3;
    localparam logic [2:0] SR_CYCLE   = 3'd4;
    localparam logic [2:0] SR_INSTRET = 3'd5;

    // Trap cause codes written into ECAUSE
    localparam logic [31:0] CAUSE_SCALL = 32'd1;
    localparam logic [31:0] CAUSE_UDF   = 32'd2;

    // Writeback state: normal run, inside a trap handler, double-fault halt
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        HALT = 2'd2
    } wb_state_t;

endpackage : br32_pkg
`default_nettype wire

// File: rtl/sr_file.sv
`default_nettype none
// ============================================================================
// Module      : sr_file
// Description : System register file for the writeback stage: EPC, ECAUSE,
//               EVEC, ESTAT (in-trap + saved compare), CYCLE and INSTRET,
//               with a combinational read port for mfsr.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_file
    import br32_pkg::*;
#(
    parameter logic [31:0] RESET_EVEC   = 32'h0000_0100,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  raddr,
    output logic [31:0] rdata,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        trap_enter,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic        trap_ret,
    input  logic [1:0]  cmp_reg,
    input  logic        retire,
    input  logic        halted,
    output logic [31:0] epc,
    output logic [31:0] evec,
    output logic [1:0]  scr
);

    logic [31:0] r_epc;
    logic [31:0] r_ecause;
    logic [31:0] r_evec;
    logic        r_in_trap;
    logic [1:0]  r_scr;
    logic [31:0] r_cycle;
    logic [31:0] r_instret;

    // Exception registers: mtsr writes first, trap entry/return take precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc     <= 32'd0;
            r_ecause  <= 32'd0;
            r_evec    <= RESET_EVEC;
            r_in_trap <= 1'b0;
            r_scr     <= 2'b00;
        end else begin
            if (we) begin
                case (waddr)
                    SR_EPC:    r_epc    <= wdata;
                    SR_ECAUSE: r_ecause <= wdata;
                    SR_EVEC:   r_evec   <= wdata;
                    SR_ESTAT: begin
                        r_in_trap <= wdata[0];
                        r_scr     <= wdata[2:1];
                    end
                    default: ;
                endcase
            end
            if (trap_enter) begin
                r_epc     <= trap_epc;
                r_ecause  <= trap_cause;
                r_scr     <= cmp_reg;
                r_in_trap <= 1'b1;
            end else if (trap_ret) begin
                r_in_trap <= 1'b0;
            end
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            // Free-running cycle and retired-instruction counters; mtsr overrides the increment
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cycle   <= 32'd0;
                    r_instret <= 32'd0;
                end else begin
                    if (we && (waddr == SR_CYCLE)) begin
                        r_cycle <= wdata;
                    end else if (!halted) begin
                        r_cycle <= r_cycle + 32'd1;
                    end
                    if (we && (waddr == SR_INSTRET)) begin
                        r_instret <= wdata;
                    end else if (retire) begin
                        r_instret <= r_instret + 32'd1;
                    end
                end
            end
        end else begin : g_no_counters
            assign r_cycle   = 32'd0;
            assign r_instret = 32'd0;
        end
    endgenerate

    // Read mux shows pre-update state so mfsr sees the value before this cycle's write
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            SR_EPC:     rdata = r_epc;
            SR_ECAUSE:  rdata = r_ecause;
            SR_EVEC:    rdata = r_evec;
            SR_ESTAT:   rdata = {29'd0, r_scr, r_in_trap};
            SR_CYCLE:   rdata = r_cycle;
            SR_INSTRET: rdata = r_instret;
            default:    rdata = 32'd0;
        endcase
    end

    assign epc  = r_epc;
    assign evec = r_evec;
    assign scr  = r_scr;

endmodule : sr_file
`default_nettype wire

// File: rtl/stage_wb.sv
`default_nettype none
// ============================================================================
// Module      : stage_wb
// Description : Writeback stage. Latches the MEM result, writes the register
//               file and compare register, and raises trap/return redirects
//               (exn) through a RUN/TRAP/HALT state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_wb
    import br32_pkg::*;
#(
    parameter logic [31:0] RESET_EVEC   = 32'h0000_0100,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_nextpc,
    input  logic [31:0] mem_res,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_op3,
    input  logic [4:0]  mem_rd,
    input  logic        mem_w_rd,
    input  logic [1:0]  mem_cmp_res,
    input  logic        mem_w_cr,
    input  logic        mem_mtsr,
    input  logic        mem_scall,
    input  logic        mem_eret,
    input  logic        mem_udf,
    input  logic        mem_bubble,
    input  logic [2:0]  sr_raddr,
    output logic [31:0] sr_rdata,
    output logic [1:0]  cmp_reg,
    output logic [1:0]  scr,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        exn,
    output logic [31:0] exn_pc,
    output logic        halted
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_nextpc;
    logic [31:0] r_res;
    logic [31:0] r_alu_res;
    logic [31:0] r_op3;
    logic [4:0]  r_rd;
    logic        r_w_rd;
    logic [1:0]  r_cmp_res;
    logic        r_w_cr;
    logic        r_mtsr;
    logic        r_scall;
    logic        r_eret;
    logic        r_udf;
    logic [1:0]  r_cmp_reg;
    wb_state_t   r_state;

    wb_state_t   w_next_state;
    logic        w_live;
    logic        w_trap;
    logic        w_eret;
    logic        w_trap_enter;
    logic        w_trap_ret;
    logic        w_exn;
    logic [31:0] w_exn_pc;
    logic [31:0] w_epc;
    logic [31:0] w_evec;
    logic [31:0] w_cause;

    // WB latch; anything arriving alongside a redirect or after halt is squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_nextpc  <= 32'd0;
            r_res     <= 32'd0;
            r_alu_res <= 32'd0;
            r_op3     <= 32'd0;
            r_rd      <= 5'd0;
            r_w_rd    <= 1'b0;
            r_cmp_res <= 2'b00;
            r_w_cr    <= 1'b0;
            r_mtsr    <= 1'b0;
            r_scall   <= 1'b0;
            r_eret    <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_valid   <= !mem_bubble && !w_exn && !halted;
            r_pc      <= mem_pc;
            r_nextpc  <= mem_nextpc;
            r_res     <= mem_res;
            r_alu_res <= mem_alu_res;
            r_op3     <= mem_op3;
            r_rd      <= mem_rd;
            r_w_rd    <= mem_w_rd;
            r_cmp_res <= mem_cmp_res;
            r_w_cr    <= mem_w_cr;
            r_mtsr    <= mem_mtsr;
            r_scall   <= mem_scall;
            r_eret    <= mem_eret;
            r_udf     <= mem_udf;
        end
    end

    assign w_live  = r_valid && (r_state != HALT);
    assign w_trap  = w_live && (r_scall || r_udf);
    assign w_eret  = w_live && r_eret;
    assign w_cause = r_udf ? CAUSE_UDF : CAUSE_SCALL;

    // Redirect decode and next-state selection from the latched instruction
    always_comb begin
        w_next_state = r_state;
        w_exn        = 1'b0;
        w_exn_pc     = 32'd0;
        w_trap_enter = 1'b0;
        w_trap_ret   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_trap) begin
                    w_exn        = 1'b1;
                    w_exn_pc     = w_evec;
                    w_trap_enter = 1'b1;
                    w_next_state = TRAP;
                end else if (w_eret) begin
                    w_exn    = 1'b1;
                    w_exn_pc = w_epc;
                end
            end
            TRAP: begin
                if (w_trap) begin
                    w_exn        = 1'b1;
                    w_exn_pc     = r_pc;
                    w_next_state = HALT;
                end else if (w_eret) begin
                    w_exn        = 1'b1;
                    w_exn_pc     = w_epc;
                    w_trap_ret   = 1'b1;
                    w_next_state = RUN;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = HALT;
        endcase
    end

    // State register and architectural compare register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cmp_reg <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_live && r_w_cr) begin
                r_cmp_reg <= r_cmp_res;
            end
        end
    end

    sr_file #(
        .RESET_EVEC   (RESET_EVEC),
        .HAS_COUNTERS (HAS_COUNTERS)
    ) u_sr_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (sr_raddr),
        .rdata      (sr_rdata),
        .we         (w_live && r_mtsr),
        .waddr      (r_alu_res[2:0]),
        .wdata      (r_op3),
        .trap_enter (w_trap_enter),
        .trap_cause (w_cause),
        .trap_epc   (r_scall ? r_nextpc : r_pc),
        .trap_ret   (w_trap_ret),
        .cmp_reg    (r_cmp_reg),
        .retire     (w_live && !r_udf),
        .halted     (halted),
        .epc        (w_epc),
        .evec       (w_evec),
        .scr        (scr)
    );

    assign rf_we    = w_live && r_w_rd && (r_rd != 5'd0) && !r_udf;
    assign rf_waddr = r_rd;
    assign rf_wdata = r_res;
    assign exn      = w_exn;
    assign exn_pc   = w_exn_pc;
    assign halted   = (r_state == HALT);
    assign cmp_reg  = r_cmp_reg;

endmodule : stage_wb
`default_nettype wire

// File: tb/tb_stage_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_wb
// Description : Directed self-checking bench for stage_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_pc, mem_nextpc, mem_res, mem_alu_res, mem_op3;
    logic [4:0]  mem_rd;
    logic        mem_w_rd;
    logic [1:0]  mem_cmp_res;
    logic        mem_w_cr, mem_mtsr, mem_scall, mem_eret, mem_udf, mem_bubble;
    logic [2:0]  sr_raddr;
    logic [31:0] sr_rdata;
    logic [1:0]  cmp_reg, scr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        exn;
    logic [31:0] exn_pc;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    stage_wb #(
        .RESET_EVEC   (32'h0000_0100),
        .HAS_COUNTERS (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_pc      (mem_pc),
        .mem_nextpc  (mem_nextpc),
        .mem_res     (mem_res),
        .mem_alu_res (mem_alu_res),
        .mem_op3     (mem_op3),
        .mem_rd      (mem_rd),
        .mem_w_rd    (mem_w_rd),
        .mem_cmp_res (mem_cmp_res),
        .mem_w_cr    (mem_w_cr),
        .mem_mtsr    (mem_mtsr),
        .mem_scall   (mem_scall),
        .mem_eret    (mem_eret),
        .mem_udf     (mem_udf),
        .mem_bubble  (mem_bubble),
        .sr_raddr    (sr_raddr),
        .sr_rdata    (sr_rdata),
        .cmp_reg     (cmp_reg),
        .scr         (scr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .exn         (exn),
        .exn_pc      (exn_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_sr(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        sr_raddr = idx;
        #1;
        chk(tag, sr_rdata, exp);
    endtask

    task automatic idle();
        mem_pc = 32'd0; mem_nextpc = 32'd0; mem_res = 32'd0;
        mem_alu_res = 32'd0; mem_op3 = 32'd0; mem_rd = 5'd0; mem_w_rd = 1'b0;
        mem_cmp_res = 2'b00; mem_w_cr = 1'b0; mem_mtsr = 1'b0; mem_scall = 1'b0;
        mem_eret = 1'b0; mem_udf = 1'b0; mem_bubble = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        sr_raddr = 3'd0;
        rst_n    = 1'b0;
        tick();
        tick();
        chk("rst_rf_we",   {31'd0, rf_we},   32'd0);
        chk("rst_exn",     {31'd0, exn},     32'd0);
        chk("rst_exn_pc",  exn_pc,           32'd0);
        chk("rst_halted",  {31'd0, halted},  32'd0);
        chk("rst_cmp_reg", {30'd0, cmp_reg}, 32'd0);
        chk("rst_scr",     {30'd0, scr},     32'd0);
        rd_sr(3'd2, 32'h0000_0100, "rst_evec");
        rd_sr(3'd0, 32'd0,         "rst_epc");
        rst_n = 1'b1;
        tick();

        // ALU writeback, then rd=0 suppressed
        mem_bubble = 1'b0; mem_rd = 5'd5; mem_w_rd = 1'b1; mem_res = 32'hDEAD_BEEF;
        tick();
        chk("wb_we",    {31'd0, rf_we}, 32'd1);
        chk("wb_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("wb_wdata", rf_wdata, 32'hDEAD_BEEF);
        mem_rd = 5'd0;
        tick();
        chk("wb_rd0_we", {31'd0, rf_we}, 32'd0);

        // Set compare register to 2'b10
        idle();
        mem_bubble = 1'b0; mem_w_cr = 1'b1; mem_cmp_res = 2'b10;
        tick();
        idle();
        tick();
        chk("cr_write", {30'd0, cmp_reg}, 32'd2);

        // scall from RUN
        mem_bubble = 1'b0; mem_scall = 1'b1; mem_pc = 32'h200; mem_nextpc = 32'h204;
        tick();
        chk("scall_exn",    {31'd0, exn}, 32'd1);
        chk("scall_exn_pc", exn_pc, 32'h100);
        idle();
        mem_bubble = 1'b0; mem_rd = 5'd7; mem_w_rd = 1'b1; mem_res = 32'h1;
        tick();
        chk("scall_exn_1cyc", {31'd0, exn}, 32'd0);
        chk("scall_squash",   {31'd0, rf_we}, 32'd0);
        chk("scall_scr",      {30'd0, scr}, 32'd2);
        rd_sr(3'd0, 32'h204, "scall_epc");
        rd_sr(3'd1, 32'd1,   "scall_ecause");
        rd_sr(3'd3, 32'd5,   "scall_estat");
        idle();

        // Inside the handler the compare register gets clobbered
        mem_bubble = 1'b0; mem_w_cr = 1'b1; mem_cmp_res = 2'b01;
        tick();
        idle();
        tick();
        chk("trap_cr", {30'd0, cmp_reg}, 32'd1);

        // eret in TRAP restores compare register via cmp_res
        mem_bubble = 1'b0; mem_eret = 1'b1; mem_w_cr = 1'b1; mem_cmp_res = 2'b10;
        tick();
        chk("eret_exn",    {31'd0, exn}, 32'd1);
        chk("eret_exn_pc", exn_pc, 32'h204);
        idle();
        tick();
        chk("eret_cmp", {30'd0, cmp_reg}, 32'd2);
        chk("eret_exn_off", {31'd0, exn}, 32'd0);
        rd_sr(3'd3, 32'd4, "eret_estat");

        // eret in RUN: redirect, remain in RUN
        mem_bubble = 1'b0; mem_eret = 1'b1;
        tick();
        chk("run_eret_exn",    {31'd0, exn}, 32'd1);
        chk("run_eret_exn_pc", exn_pc, 32'h204);
        idle();
        tick();
        rd_sr(3'd3, 32'd4, "run_eret_estat");

        // Enter TRAP again (scall), then udf -> double fault
        mem_bubble = 1'b0; mem_scall = 1'b1; mem_pc = 32'h300; mem_nextpc = 32'h304;
        tick();
        chk("scall2_exn", {31'd0, exn}, 32'd1);
        idle();
        tick();
        mem_bubble = 1'b0; mem_udf = 1'b1; mem_pc = 32'h400; mem_rd = 5'd3; mem_w_rd = 1'b1;
        tick();
        chk("df_exn",    {31'd0, exn}, 32'd1);
        chk("df_exn_pc", exn_pc, 32'h400);
        chk("df_no_rf",  {31'd0, rf_we}, 32'd0);
        idle();
        mem_bubble = 1'b0; mem_rd = 5'd4; mem_w_rd = 1'b1; mem_res = 32'h55;
        tick();
        chk("halted", {31'd0, halted}, 32'd1);
        mem_scall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_quiet", {30'd0, rf_we, exn}, 32'd0);
        end

        // Async reset leaves HALT
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_unhalt", {31'd0, halted}, 32'd0);
        rd_sr(3'd2, 32'h100, "rst2_evec");
        tick();
        rst_n = 1'b1;
        tick();

        // mtsr CYCLE = all ones, then wrap
        mem_bubble = 1'b0; mem_mtsr = 1'b1; mem_alu_res = 32'd4; mem_op3 = 32'hFFFF_FFFF;
        tick();
        idle();
        tick();
        rd_sr(3'd4, 32'hFFFF_FFFF, "cycle_wr");
        tick();
        rd_sr(3'd4, 32'd0, "cycle_wrap");

        // mtsr to unimplemented index 7
        mem_bubble = 1'b0; mem_mtsr = 1'b1; mem_alu_res = 32'd7; mem_op3 = 32'h1234;
        tick();
        idle();
        tick();
        rd_sr(3'd7, 32'd0, "sr7_zero");

        // Preset INSTRET=50 then CYCLE=100; the CYCLE mtsr itself retires
        mem_bubble = 1'b0; mem_mtsr = 1'b1; mem_alu_res = 32'd5; mem_op3 = 32'd50;
        tick();
        mem_alu_res = 32'd4; mem_op3 = 32'd100;
        tick();
        idle();
        tick();
        rd_sr(3'd4, 32'd100, "preset_cycle");
        rd_sr(3'd5, 32'd51,  "preset_instret");

        // Bubble stream of 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bubble_no_we", {31'd0, rf_we}, 32'd0);
        end
        rd_sr(3'd4, 32'd105, "bubble_cycle");
        rd_sr(3'd5, 32'd51,  "bubble_instret");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stage_wb
`default_nettype wire
